// File: rtl/isa16_pkg.sv
// isa16_pkg: shared types and constants for the 16-bit processor.
package isa16_pkg;
    localparam int IMEM_ADDR_W = 10;
    localparam logic [7:0] LOADER_SYNC = 8'hA5;
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
    } loader_state_t;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: writes a framed, XOR-checked byte stream into instruction memory
// and holds the core in reset until a verified image is in place.
module imem_loader
    import isa16_pkg::*;
#(
    parameter int         ADDR_W    = IMEM_ADDR_W,
    parameter logic [7:0] SYNC_BYTE = LOADER_SYNC
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_resetn,
    output logic              done,
    output logic              error
);
    // One extra index bit so a full 2^ADDR_W-word image still terminates.
    localparam int IW = ADDR_W + 1;
    loader_state_t     state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, len_q, len_d, nxt_idx;
    logic [7:0]        hi_q, hi_d, chk_q, chk_d;
    logic              we_q, we_d, done_q, done_d, err_q, err_d, run_q, run_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d, n;
    logic              acc, sync, len_bad, chk_ok;
    assign rx_ready = state_q != WRITE;
    assign acc      = rx_valid && rx_ready;
    assign sync     = acc && rx_byte == SYNC_BYTE;
    assign n        = {hi_q, rx_byte};
    assign len_bad  = n == 16'd0 || 32'(n) > (32'd1 << ADDR_W);
    assign chk_ok   = rx_byte == chk_q;
    assign nxt_idx  = idx_q + IW'(1);
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        hi_d    = hi_q;
        chk_d   = chk_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        run_d   = run_q;
        case (state_q)
            IDLE:    if (sync) state_d = LEN_HI;
            LEN_HI:  if (acc) begin
                hi_d    = rx_byte;
                state_d = LEN_LO;
            end
            LEN_LO:  if (acc) begin
                idx_d   = '0;
                chk_d   = '0;
                len_d   = n[IW-1:0];
                err_d   = len_bad;
                state_d = len_bad ? ERROR : DATA_HI;
            end
            DATA_HI: if (acc) begin
                hi_d    = rx_byte;
                chk_d   = chk_q ^ rx_byte;
                state_d = DATA_LO;
            end
            DATA_LO: if (acc) begin
                chk_d   = chk_q ^ rx_byte;
                we_d    = 1'b1;
                addr_d  = idx_q[ADDR_W-1:0];
                wdata_d = {hi_q, rx_byte};
                state_d = WRITE;
            end
            WRITE: begin
                idx_d   = nxt_idx;
                state_d = nxt_idx == len_q ? CHECK : DATA_HI;
            end
            CHECK:   if (acc) begin
                done_d  = chk_ok;
                run_d   = chk_ok;
                err_d   = !chk_ok;
                state_d = chk_ok ? DONE : ERROR;
            end
            DONE:    if (sync) begin
                done_d  = 1'b0;
                run_d   = 1'b0;
                state_d = LEN_HI;
            end
            ERROR:   if (sync) begin
                err_d   = 1'b0;
                state_d = LEN_HI;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            hi_q    <= '0;
            chk_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            chk_q   <= chk_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign error      = err_q;
    assign cpu_resetn = run_q & resetn;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus checked against a frame-level
// reference model of the loader.
module tb_imem_loader;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_ready, imem_we, cpu_resetn, done, error;
    logic [9:0] imem_addr;
    logic [15:0] imem_wdata;

    imem_loader #(.ADDR_W(10)) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_resetn(cpu_resetn), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [25:0] exp_w[$], got_w[$];
    int          exp_lo[$], got_cyc[$], acc_edge[$];
    bit          mdone = 1'b0, merr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level model: parses the whole stream, listing the writes it must
    // produce, the stream index of each word's lo byte, and the final status.
    function automatic void model(input byte_q_t q);
        int i = 0;
        int n, w;
        logic [7:0] c;
        exp_w.delete();
        exp_lo.delete();
        while (i < q.size()) begin
            if (q[i] != 8'hA5) begin
                i++;
                continue;
            end
            mdone = 1'b0;
            merr  = 1'b0;
            if (i + 2 >= q.size()) break;
            n = {q[i+1], q[i+2]};
            i += 3;
            if (n == 0 || n > 1024) begin
                merr = 1'b1;
                continue;
            end
            c = 8'h00;
            for (w = 0; w < n && i + 1 < q.size(); w++) begin
                exp_w.push_back({w[9:0], q[i], q[i+1]});
                exp_lo.push_back(i + 1);
                c ^= q[i] ^ q[i+1];
                i += 2;
            end
            if (w < n || i >= q.size()) break;
            mdone = q[i] == c;
            merr  = !mdone;
            i++;
        end
    endfunction

    always @(negedge clk) begin
        if (resetn) begin
            if (imem_we) begin
                got_w.push_back({imem_addr, imem_wdata});
                got_cyc.push_back(cyc);
            end
            if (imem_we || !rx_ready) check("ready_vs_we", 32'(rx_ready), 32'(!imem_we));
        end
    end

    task automatic drive(input byte_q_t q, input int gap, input int split);
        int t;
        bit a;
        for (int i = 0; i < q.size(); i++) begin
            if (i == split) begin
                @(negedge clk);
                rx_valid = 1'b0;
                #1;
                check("reload_cpu_resetn", 32'(cpu_resetn), 0);
                check("reload_done", 32'(done), 0);
            end
            t = 0;
            a = 1'b0;
            while (!a) begin
                @(negedge clk);
                rx_valid = $urandom_range(99) >= gap;
                rx_byte  = rx_valid ? q[i] : 8'($urandom);
                a = rx_valid && rx_ready;
                if (a) acc_edge.push_back(cyc + 1);
                @(posedge clk);
                t++;
                if (!a && t > 64) begin
                    check("accept_timeout", 32'(t), 64);
                    return;
                end
            end
        end
    endtask

    task automatic verify(input string tag);
        check({tag, "_nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
            check({tag, "_write"}, 32'(got_w[k]), 32'(exp_w[k]));
            if (exp_lo[k] < acc_edge.size())
                check({tag, "_we_latency"}, 32'(got_cyc[k]), 32'(acc_edge[exp_lo[k]]));
        end
        check({tag, "_done"}, 32'(done), 32'(mdone));
        check({tag, "_error"}, 32'(error), 32'(merr));
        check({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'(mdone));
        got_w.delete();
        got_cyc.delete();
    endtask

    task automatic run(input string tag, input byte_q_t q, input int gap, input int split);
        model(q);
        acc_edge.delete();
        drive(q, gap, split);
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        verify(tag);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"}, 32'(imem_we), 0);
        check({tag, "_addr"}, 32'(imem_addr), 0);
        check({tag, "_wdata"}, 32'(imem_wdata), 0);
        check({tag, "_cpu_resetn"}, 32'(cpu_resetn), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_ready"}, 32'(rx_ready), 1);
    endtask

    task automatic build(input int n, input bit bad, input int pre, output byte_q_t q);
        logic [7:0] b, c;
        q.delete();
        repeat (pre) begin
            b = 8'($urandom);
            q.push_back(b == 8'hA5 ? 8'h00 : b);
        end
        q.push_back(8'hA5);
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        c = 8'h00;
        repeat (2 * n) begin
            b = 8'($urandom);
            c ^= b;
            q.push_back(b);
        end
        q.push_back(bad ? c ^ 8'($urandom_range(1, 255)) : c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t good, bad, q;
        int t;
        good = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2E};
        #3;
        check_reset("rst_async");
        repeat (2) @(negedge clk);
        check_reset("rst_held");
        resetn = 1'b1;

        run("good", good, 30, -1);
        bad = good;
        bad[bad.size() - 1] = 8'h2F;
        run("bad_chk", bad, 30, -1);
        run("resend_stall", good, 0, -1);
        q = '{8'hA5, 8'h00, 8'h00};
        run("len_zero", q, 20, -1);
        q = '{8'hA5, 8'h04, 8'h01};
        run("len_big", q, 20, -1);
        q = good;
        q.push_front(8'h5A);
        q.push_front(8'hFF);
        q.push_front(8'h00);
        run("garbage", q, 10, -1);

        q = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78};
        model(q);
        acc_edge.delete();
        drive(q, 0, -1);
        t = 0;
        while (got_w.size() < 2 && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("pre_reset_writes", 32'(got_w.size()), 2);
        rx_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        check_reset("rst_mid");
        mdone = 1'b0;
        merr  = 1'b0;
        verify("partial");
        @(negedge clk);
        resetn = 1'b1;
        run("after_reset", good, 20, -1);

        build(2, 1'b0, 0, q);
        run("reload", q, 20, 1);

        for (int r = 0; r < 8; r++) begin
            build($urandom_range(1, 6), $urandom_range(99) < 30, $urandom_range(3), q);
            run("rand", q, $urandom_range(50), -1);
        end

        build(1024, 1'b0, 0, q);
        run("full_image", q, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

- Boot-time writer for the 16-bit processor's instruction memory.
- Receives a framed byte stream over a valid/ready link, assembles big-endian 16-bit instruction words and writes them to consecutive instruction-memory addresses starting at 0.
- Holds the CPU core in reset until a complete, checksum-verified image has been written.
- Sits between the serial-receive front end and the instruction RAM, which the datapath reads during normal execution.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width. Image capacity is 2^ADDR_W words.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk` input, 1 bit: system clock. All state changes on the rising edge.
- `resetn` input, 1 bit: asynchronous, active-low reset.
- `rx_valid` input, 1 bit: `rx_byte` holds a valid byte.
- `rx_byte` input, 8 bits: incoming stream byte.
- `rx_ready` output, 1 bit: loader can accept a byte this cycle.
- `imem_we` output, 1 bit: instruction-memory write strobe, one cycle per word.
- `imem_addr` output, ADDR_W bits: write word address.
- `imem_wdata` output, 16 bits: write data, `{hi_byte, lo_byte}`.
- `cpu_resetn` output, 1 bit: active-low reset to the core and its PC. Low until a load succeeds.
- `done` output, 1 bit: image loaded and verified.
- `error` output, 1 bit: last frame was rejected.

## Operation
- Frame format: `SYNC_BYTE`, `LEN_HI`, `LEN_LO`, then N word pairs (hi byte, lo byte), then `CHK`.
  - N = {LEN_HI, LEN_LO}.
  - `CHK` is the XOR of all 2N payload bytes only. Sync and length bytes are excluded.
- Transfer rule: a byte is accepted in a cycle where `rx_valid && rx_ready`. Bytes are never accepted while `resetn` is low.
- State machine, states `IDLE`, `LEN_HI`, `LEN_LO`, `DATA_HI`, `DATA_LO`, `WRITE`, `CHECK`, `DONE`, `ERROR`:
  - `IDLE`: a byte equal to `SYNC_BYTE` moves to `LEN_HI`. Any other byte is consumed and discarded.
  - `LEN_HI` -> `LEN_LO` on accept.
  - `LEN_LO` -> `DATA_HI` on accept.
    - If N == 0 or N > 2^ADDR_W, go to `ERROR` instead.
    - Clear the word index and the running checksum.
  - `DATA_HI` -> `DATA_LO` on accept. Latch the hi byte and XOR it into the checksum.
  - `DATA_LO` -> `WRITE` on accept. XOR the lo byte into the checksum.
  - `WRITE` (exactly 1 cycle):
    - `imem_we`=1, `imem_addr`=word index, `imem_wdata`={hi, lo}.
    - Then increment the index and go to `DATA_HI`, or to `CHECK` if this was word N-1.
  - `CHECK`: on accept, go to `DONE` if `CHK` equals the running checksum, else `ERROR`.
  - `DONE`:
    - Registered outputs `done`=1 and `cpu_resetn`=1 from the edge that enters `DONE`.
    - Accepting `SYNC_BYTE` starts a reload: `done` and `cpu_resetn` clear on that edge and the state goes to `LEN_HI`. Other bytes are discarded.
  - `ERROR`:
    - `error`=1, `cpu_resetn`=0, `done`=0.
    - `SYNC_BYTE` clears `error` and goes to `LEN_HI`. Other bytes are discarded.
- Words already written before a checksum or length failure are not erased. The core stays in reset.
- Word index width is ADDR_W+1 so that N = 2^ADDR_W terminates correctly. The top address written is 2^ADDR_W - 1.

## Timing
- Reset values: state `IDLE`, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_resetn`=0, `done`=0, `error`=0.
- `rx_ready` is combinational from state: 0 in `WRITE`, 1 in every other state.
- The sender must hold the byte across a `WRITE` cycle. That byte is accepted in the following cycle.
- Throughput: at most 2 bytes per 3 cycles during data, 1 byte per cycle elsewhere.
- Write latency: `imem_we` asserts in the cycle immediately after the lo byte is accepted.
- `imem_addr` and `imem_wdata` are valid only while `imem_we`=1. Outside that cycle they hold their last values.
- `cpu_resetn` and `done` rise on the same edge that accepts a correct `CHK`. Error detection on `CHK` or length sets `error` on the accepting edge.
- `rx_valid` gaps are legal in every state. The FSM waits without timeout.
- Reset mid-frame, asserted asynchronously:
  - All outputs return to reset values immediately.
  - The partial load is abandoned. The next frame writes from address 0.

## Structure
- Shared `isa16_pkg` holds:
  - `loader_state_t` enum.
  - `IMEM_ADDR_W` = 10, the default for `ADDR_W`.
  - `LOADER_SYNC` = 8'hA5.
- Single module. No sub-module: the FSM, byte latch, word counter and XOR accumulator are inline.
- The top level routes `cpu_resetn` into the core reset network (AND with `resetn`).

## Test plan
- Good 3-word frame `A5 00 03 12 34 56 78 9A BC 2E` -> writes (0,1234), (1,5678), (2,9ABC), each a 1-cycle `imem_we`; `done`=1, `cpu_resetn`=1, `error`=0.
- Same frame with `CHK`=2F -> three writes occur, then `error`=1, `done`=0, `cpu_resetn`=0. Resending the good frame -> `done`=1, `error`=0.
- Length `00 00` and, separately, length `04 01` -> `error`=1 on the `LEN_LO` accept, zero writes.
- Leading garbage `00 FF 5A` before a valid frame -> garbage discarded; load completes identically to the first scenario.
- `rx_valid` held continuously high with a byte stalled over each `WRITE` -> `rx_ready`=0 exactly one cycle after each lo byte, no byte lost or duplicated.
- `resetn` pulsed low after the second word of a 3-word load -> outputs reset immediately. A fresh good frame writes from address 0. A reload after `DONE` drops `cpu_resetn` on the sync byte.
